pc_unit: RTL

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 110 +++++++++++
 1 files changed

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with optional return-address stack (enabled by PC_STACK_EN)
module pc_unit #(
    parameter int                 WIDTH        = 8,
    parameter int                 STACK_DEPTH  = 4,
    parameter logic [WIDTH-1:0]   RESET_VECTOR = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch,
    input  logic [WIDTH-1:0] target,
    input  logic             rel,
    input  logic [WIDTH-1:0] offset,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] pc,
    output logic             stack_empty,
    output logic             stack_full,
    output logic             stack_err
);

    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] top;
    logic             pop_ok;

    assign pc_inc = pc + WIDTH'(1);

    // A ret that cannot pop falls back to a plain increment.
    always_comb begin
        pc_next = pc;
        if (!stall) begin
            if (ret) begin
                pc_next = pop_ok ? top : pc_inc;
            end else if (call || branch) begin
                pc_next = target;
            end else if (rel) begin
                pc_next = pc + offset;
            end else begin
                pc_next = pc_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_VECTOR;
        end else begin
            pc <= pc_next;
        end
    end

`ifdef PC_STACK_EN
    localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int CNT_W = $clog2(STACK_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(STACK_DEPTH);

    logic [WIDTH-1:0] mem [STACK_DEPTH];
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wr_idx;
    logic [PTR_W-1:0] rd_idx;
    logic             do_push;
    logic             do_pop;
    logic             err_set;
    logic             err_q;

    // Depth is a power of two, so the low count bits wrap to the top slot when full.
    assign wr_idx      = count[PTR_W-1:0];
    assign rd_idx      = wr_idx - PTR_W'(1);
    assign top         = mem[rd_idx];
    assign stack_empty = (count == '0);
    assign stack_full  = (count == FULL_CNT);
    assign pop_ok      = !stack_empty;
    assign stack_err   = err_q;

    assign do_pop  = !stall && ret && pop_ok;
    assign do_push = !stall && !ret && call && !stack_full;
    assign err_set = !stall && ((ret && !pop_ok) || (!ret && call && stack_full));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            err_q <= 1'b0;
        end else begin
            if (do_push) begin
                count <= count + CNT_W'(1);
            end else if (do_pop) begin
                count <= count - CNT_W'(1);
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    // Entry storage is never reset; occupancy alone decides what is readable.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= pc_inc;
        end
    end
`else
    assign pop_ok      = 1'b0;
    assign top         = '0;
    assign stack_empty = 1'b1;
    assign stack_full  = 1'b0;
    assign stack_err   = 1'b0;
`endif

endmodule
